// File: rtl/pp_compressor_22.sv
// pp_compressor_22: Wallace-tree reduction of 43 diamond-shaped columns plus final 45-bit adder.
// Define COMPRESSOR_MIDREG_EN to register the two reduced rows (latency 2 instead of 1).
module pp_compressor_22 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        src0,
    input  logic [1:0]  src1,
    input  logic [2:0]  src2,
    input  logic [3:0]  src3,
    input  logic [4:0]  src4,
    input  logic [5:0]  src5,
    input  logic [6:0]  src6,
    input  logic [7:0]  src7,
    input  logic [8:0]  src8,
    input  logic [9:0]  src9,
    input  logic [10:0] src10,
    input  logic [11:0] src11,
    input  logic [12:0] src12,
    input  logic [13:0] src13,
    input  logic [14:0] src14,
    input  logic [15:0] src15,
    input  logic [16:0] src16,
    input  logic [17:0] src17,
    input  logic [18:0] src18,
    input  logic [19:0] src19,
    input  logic [20:0] src20,
    input  logic [21:0] src21,
    input  logic [20:0] src22,
    input  logic [19:0] src23,
    input  logic [18:0] src24,
    input  logic [17:0] src25,
    input  logic [16:0] src26,
    input  logic [15:0] src27,
    input  logic [14:0] src28,
    input  logic [13:0] src29,
    input  logic [12:0] src30,
    input  logic [11:0] src31,
    input  logic [10:0] src32,
    input  logic [9:0]  src33,
    input  logic [8:0]  src34,
    input  logic [7:0]  src35,
    input  logic [6:0]  src36,
    input  logic [5:0]  src37,
    input  logic [4:0]  src38,
    input  logic [3:0]  src39,
    input  logic [2:0]  src40,
    input  logic [1:0]  src41,
    input  logic        src42,
    output logic        out_valid,
    output logic        dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7,
    output logic        dst8, dst9, dst10, dst11, dst12, dst13, dst14, dst15,
    output logic        dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23,
    output logic        dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31,
    output logic        dst32, dst33, dst34, dst35, dst36, dst37, dst38, dst39,
    output logic        dst40, dst41, dst42, dst43, dst44
);

    // Wallace row counts per level: n -> 2*(n/3) + n%3
    localparam int H [8] = '{22, 15, 10, 7, 5, 4, 3, 2};

    logic [21:0] col [43];
    logic [44:0] row [8][22];
    logic [44:0] sum_row, carry_row, total, sum_q;
    logic        total_valid;

    assign col[0]  = 22'(src0);
    assign col[1]  = 22'(src1);
    assign col[2]  = 22'(src2);
    assign col[3]  = 22'(src3);
    assign col[4]  = 22'(src4);
    assign col[5]  = 22'(src5);
    assign col[6]  = 22'(src6);
    assign col[7]  = 22'(src7);
    assign col[8]  = 22'(src8);
    assign col[9]  = 22'(src9);
    assign col[10] = 22'(src10);
    assign col[11] = 22'(src11);
    assign col[12] = 22'(src12);
    assign col[13] = 22'(src13);
    assign col[14] = 22'(src14);
    assign col[15] = 22'(src15);
    assign col[16] = 22'(src16);
    assign col[17] = 22'(src17);
    assign col[18] = 22'(src18);
    assign col[19] = 22'(src19);
    assign col[20] = 22'(src20);
    assign col[21] = src21;
    assign col[22] = 22'(src22);
    assign col[23] = 22'(src23);
    assign col[24] = 22'(src24);
    assign col[25] = 22'(src25);
    assign col[26] = 22'(src26);
    assign col[27] = 22'(src27);
    assign col[28] = 22'(src28);
    assign col[29] = 22'(src29);
    assign col[30] = 22'(src30);
    assign col[31] = 22'(src31);
    assign col[32] = 22'(src32);
    assign col[33] = 22'(src33);
    assign col[34] = 22'(src34);
    assign col[35] = 22'(src35);
    assign col[36] = 22'(src36);
    assign col[37] = 22'(src37);
    assign col[38] = 22'(src38);
    assign col[39] = 22'(src39);
    assign col[40] = 22'(src40);
    assign col[41] = 22'(src41);
    assign col[42] = 22'(src42);

    always_comb begin
        logic [44:0] a, b, c;
        a = '0;
        b = '0;
        c = '0;
        for (int l = 0; l < 8; l++)
            for (int r = 0; r < 22; r++)
                row[l][r] = '0;
        // Row r holds bit r of every column; absent bits are zero.
        for (int r = 0; r < 22; r++)
            for (int i = 0; i < 43; i++)
                row[0][r][i] = col[i][r];
        for (int l = 0; l < 7; l++) begin
            for (int g = 0; g < 7; g++) begin
                if (g < H[l] / 3) begin
                    a = row[l][3*g];
                    b = row[l][3*g+1];
                    c = row[l][3*g+2];
                    row[l+1][2*g]   = a ^ b ^ c;
                    row[l+1][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
                end
            end
            for (int r = 0; r < 2; r++)
                if (r < H[l] % 3)
                    row[l+1][2*(H[l]/3)+r] = row[l][3*(H[l]/3)+r];
        end
    end

    assign sum_row   = row[7][0];
    assign carry_row = row[7][1];

`ifdef COMPRESSOR_MIDREG_EN
    logic [44:0] mid_sum, mid_carry;
    logic        mid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_sum   <= '0;
            mid_carry <= '0;
            mid_valid <= 1'b0;
        end else begin
            mid_sum   <= sum_row;
            mid_carry <= carry_row;
            mid_valid <= in_valid;
        end
    end

    assign total       = mid_sum + mid_carry;
    assign total_valid = mid_valid;
`else
    assign total       = sum_row + carry_row;
    assign total_valid = in_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            sum_q     <= total;
            out_valid <= total_valid;
        end
    end

    assign {dst44, dst43, dst42, dst41, dst40, dst39, dst38, dst37, dst36,
            dst35, dst34, dst33, dst32, dst31, dst30, dst29, dst28, dst27,
            dst26, dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18,
            dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,
            dst8, dst7, dst6, dst5, dst4, dst3, dst2, dst1, dst0} = sum_q;

endmodule

// File: tb/tb_pp_compressor_22.sv
// tb_pp_compressor_22: directed and streaming multiplier-equivalence checks.
// Latency follows COMPRESSOR_MIDREG_EN (2 when defined, else 1).
module tb_pp_compressor_22;

`ifdef COMPRESSOR_MIDREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic        v;
        logic [63:0] s;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [21:0] tcol [43];
    logic        out_valid;
    logic [44:0] dst;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t hist [$];

    always #5 clk = ~clk;

    pp_compressor_22 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .src0(tcol[0][0]),        .src1(tcol[1][1:0]),
        .src2(tcol[2][2:0]),      .src3(tcol[3][3:0]),
        .src4(tcol[4][4:0]),      .src5(tcol[5][5:0]),
        .src6(tcol[6][6:0]),      .src7(tcol[7][7:0]),
        .src8(tcol[8][8:0]),      .src9(tcol[9][9:0]),
        .src10(tcol[10][10:0]),   .src11(tcol[11][11:0]),
        .src12(tcol[12][12:0]),   .src13(tcol[13][13:0]),
        .src14(tcol[14][14:0]),   .src15(tcol[15][15:0]),
        .src16(tcol[16][16:0]),   .src17(tcol[17][17:0]),
        .src18(tcol[18][18:0]),   .src19(tcol[19][19:0]),
        .src20(tcol[20][20:0]),   .src21(tcol[21][21:0]),
        .src22(tcol[22][20:0]),   .src23(tcol[23][19:0]),
        .src24(tcol[24][18:0]),   .src25(tcol[25][17:0]),
        .src26(tcol[26][16:0]),   .src27(tcol[27][15:0]),
        .src28(tcol[28][14:0]),   .src29(tcol[29][13:0]),
        .src30(tcol[30][12:0]),   .src31(tcol[31][11:0]),
        .src32(tcol[32][10:0]),   .src33(tcol[33][9:0]),
        .src34(tcol[34][8:0]),    .src35(tcol[35][7:0]),
        .src36(tcol[36][6:0]),    .src37(tcol[37][5:0]),
        .src38(tcol[38][4:0]),    .src39(tcol[39][3:0]),
        .src40(tcol[40][2:0]),    .src41(tcol[41][1:0]),
        .src42(tcol[42][0]),
        .out_valid(out_valid),
        .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),
        .dst4(dst[4]),   .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),
        .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
        .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]),
        .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
        .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]),
        .dst24(dst[24]), .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]),
        .dst28(dst[28]), .dst29(dst[29]), .dst30(dst[30]), .dst31(dst[31]),
        .dst32(dst[32]), .dst33(dst[33]), .dst34(dst[34]), .dst35(dst[35]),
        .dst36(dst[36]), .dst37(dst[37]), .dst38(dst[38]), .dst39(dst[39]),
        .dst40(dst[40]), .dst41(dst[41]), .dst42(dst[42]), .dst43(dst[43]),
        .dst44(dst[44])
    );

    function automatic int ht(int i);
        return (i <= 21) ? i + 1 : 43 - i;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cols();
        for (int i = 0; i < 43; i++) tcol[i] = '0;
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 43; i++)
            for (int j = 0; j < 22; j++)
                tcol[i][j] = (j < ht(i));
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 43; i++) tcol[i] = 22'($urandom);
    endtask

    // AND-array partial products: column i gets a[j]&b[i-j]
    task automatic fill_pp(input logic [21:0] a, input logic [21:0] b);
        int lo, n;
        clear_cols();
        for (int i = 0; i < 43; i++) begin
            lo = (i > 21) ? i - 21 : 0;
            n = 0;
            for (int j = lo; j <= 21 && j <= i; j++) begin
                tcol[i][n] = a[j] & b[i-j];
                n++;
            end
        end
    endtask

    task automatic hold_check(input string tag, input logic [63:0] exp);
        in_valid = 1'b1;
        repeat (LAT) step();
        check(tag, 64'(dst), exp);
        check({tag, "_v"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        logic [21:0] a, b;
        logic        v;
        ent_t        e;

        clear_cols();
        // Reset held with live random traffic
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fill_rand();
            step();
            check("rst_dst", 64'(dst), 64'd0);
            check("rst_v", 64'(out_valid), 64'd0);
        end

        clear_cols();
        rst_n = 1'b1;
        hold_check("zero", 64'd0);

        tcol[0] = 22'd1;
        hold_check("src0", 64'd1);

        clear_cols();
        tcol[42] = 22'd1;
        hold_check("src42", 64'h400_0000_0000);

        clear_cols();
        tcol[21] = 22'h3F_FFFF;
        hold_check("col21", 64'h2C0_0000);

        fill_ones();
        hold_check("sat", 64'hFFF_FF80_0001);

        // Streaming: outputs lag the pushed inputs by LAT edges
        hist = {};
        for (int k = 0; k < LAT - 1; k++) begin
            e.v = 1'b1;
            e.s = 64'hFFF_FF80_0001;
            hist.push_back(e);
        end
        for (int k = 0; k < 40; k++) begin
            unique case (k)
                0: begin a = 22'h3F_FFFF; b = 22'h3F_FFFF; end
                1: begin a = 22'h00_0001; b = 22'h3F_FFFF; end
                2: begin a = 22'h2A_AAAA; b = 22'h15_5555; end
                default: begin a = 22'($urandom); b = 22'($urandom); end
            endcase
            v = (k < 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            fill_pp(a, b);
            in_valid = v;
            e.v = v;
            e.s = 64'(a) * 64'(b);
            hist.push_back(e);
            step();
            e = hist.pop_front();
            check($sformatf("mul%0d", k), 64'(dst), e.s);
            check($sformatf("mul%0d_v", k), 64'(out_valid), 64'(e.v));
        end

        // Async clear between edges, no clock edge involved
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dst", 64'(dst), 64'd0);
        check("arst_v", 64'(out_valid), 64'd0);

        fill_pp(22'd3, 22'd5);
        in_valid = 1'b1;
        step();
        check("arst_hold", 64'(dst), 64'd0);
        rst_n = 1'b1;
        hold_check("post_rst", 64'd15);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
